pipe_rca_add: RTL
=================

// Module: pipe_rca_add
// PURPOSE
//  Parametrised, pipelined ripple-carry add/subtract unit: the clocked, width-generic successor of the fixed 9-bit full-adder chain.
//  The carry chain is split into STAGES segments with a register after each, so long neuron-state words (membrane potential, weight sums) close timing.
//  Sits between the synapse weight fetch and the membrane-potential register; valid/ready on both sides.
// PARAMETERS
//  WIDTH   9  operand/result width in bits, >=2
//  STAGES  3  pipeline segments (1..WIDTH); latency in cycles
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand set present
//  in_ready   out  1      unit accepts operand set this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry in (ignored when sub=1)
//  sub        in   1      1: compute a - b (b inverted, carry in forced 1)
//  out_valid  out  1      result present
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      carry out of MSB (sub: 1 = no borrow)
//  ovf        out  1      two's-complement overflow of this result
//  ovf_sticky out  1      OR of ovf over all results handed off since clear
//  clr_ovf    in   1      synchronous clear of ovf_sticky
// BEHAVIOUR
//  - One clock, clk. Reset is asynchronous, active-low (rst_n); all state registers clear immediately on assertion.
//  - Reset values: out_valid=0, sum=0, cout=0, ovf=0, ovf_sticky=0. Every stage valid bit=0.
//  - in_ready=1 out of reset.
//  - SEG = ceil(WIDTH/STAGES). Segment k covers bits [k*SEG .. min((k+1)*SEG, WIDTH)-1].
//  - Trailing segments may be narrower or empty. An empty segment is a pure delay stage.
//  - Stage k adds segment k of a and b' (b' = sub ? ~b : b) using the registered carry from stage k-1.
//  - Stage 0 carry in = sub ? 1 : cin.
//  - Completed low sum bits are carried forward unchanged; unprocessed high operand bits are delayed alongside (de-skew). Bit-exact with a WIDTH-bit a+b'+c0.
//  - Global advance: en = !out_valid || out_ready; in_ready = en (combinational).
//  - en=1: every stage register and its valid bit shift one stage.
//    - Stage 0 valid loads in_valid.
//    - out_valid loads the last-stage valid.
//  - en=0: all pipeline registers hold; sum/cout/ovf held stable while out_valid=1.
//  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
//  - Latency: exactly STAGES cycles from input transfer to out_valid=1 with no stall; stall cycles add 1:1.
//  - Throughput: 1 result per cycle when out_ready held high; bubbles (in_valid=0) propagate as invalid slots and are not collapsed.
//  - ovf = carry into MSB XOR carry out of MSB, computed in the stage holding the MSB.
//  - ovf_sticky sets on the cycle of an output transfer with ovf=1.
//    - clr_ovf=1 clears it.
//    - Simultaneous set and clear: set wins (sticky=1).
//    - clr_ovf has no effect on pipeline data.
//  - sum/cout/ovf are don't-care when out_valid=0; the RTL holds them at their last value.
//  - Reset mid-operation: all in-flight results are discarded; no out_valid after release until new inputs are accepted.
//  - STAGES=1: single segment, one output register, latency 1.
// TESTING (WIDTH=9, STAGES=3 unless noted)
//  1. a=255,b=1,cin=0,sub=0, out_ready=1 -> 3 cycles later out_valid=1, sum=256, cout=0, ovf=1, ovf_sticky=1.
//  2. a=511,b=1,cin=0 -> sum=0, cout=1, ovf=0. Then a=5,b=7,sub=1 -> sum=510 (0x1FE), cout=0, ovf=0.
//  3. Back-to-back stream a=i,b=2i,i=0..15, out_ready=1 -> 16 consecutive out_valid cycles, sum=3i, in order, no gaps.
//  4. Stream with out_ready=0 for 4 cycles once the pipe is full:
//     -> in_ready=0 during the stall; sum stable; no result lost or duplicated after release.
//  5. ovf result handed off while clr_ovf=1 -> ovf_sticky=1. Next cycle clr_ovf=1, no ovf -> ovf_sticky=0.
//  6. rst_n low for 1 cycle with 3 results in flight -> out_valid=0 and ovf_sticky=0 immediately; no stale result after release.
//  - Repeat 1-3 with STAGES=1 (latency 1) and WIDTH=16, STAGES=5 (SEG=4, empty last segment; latency 5).
//    Random a/b/cin/sub vs reference model.

Source files
------------

// File: rtl/pipe_rca_add.sv
// Pipelined, width-generic ripple-carry add/subtract with valid/ready handshake.
// The carry chain is cut into STAGES segments; unprocessed operand bits travel alongside.
module pipe_rca_add #(
    parameter int unsigned WIDTH  = 9,
    parameter int unsigned STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             ovf_sticky,
    input  logic             clr_ovf
);

    localparam int unsigned SEG = (WIDTH + STAGES - 1) / STAGES;

    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] ov_q;
    logic [STAGES-1:0] v_q;

    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [STAGES-1:0] c_d;
    logic [STAGES-1:0] ov_d;
    logic [STAGES-1:0] v_d;

    logic en;

    // Ripple the bits owned by segment k; returns {ovf, carry, sum}.
    function automatic logic [WIDTH+1:0] add_seg(
        input int unsigned      k,
        input logic [WIDTH-1:0] pa,
        input logic [WIDTH-1:0] pb,
        input logic [WIDTH-1:0] ps,
        input logic             pc,
        input logic             pov
    );
        logic [WIDTH-1:0] s;
        logic             c;
        logic             cn;
        logic             ov;
        s  = ps;
        c  = pc;
        ov = pov;
        cn = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i / SEG == k) begin
                s[i] = pa[i] ^ pb[i] ^ c;
                cn   = (pa[i] & pb[i]) | (c & (pa[i] ^ pb[i]));
                if (i == WIDTH - 1) begin
                    ov = c ^ cn;
                end
                c = cn;
            end
        end
        return {ov, c, s};
    endfunction

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Next value of every stage register: stage 0 from the ports, stage k from stage k-1.
    always_comb begin
        logic [WIDTH+1:0] r;
        logic [WIDTH-1:0] bp;
        bp      = sub ? ~b : b;
        r       = add_seg(0, a, bp, '0, sub | cin, 1'b0);
        a_d[0]  = a;
        b_d[0]  = bp;
        s_d[0]  = r[WIDTH-1:0];
        c_d[0]  = r[WIDTH];
        ov_d[0] = r[WIDTH+1];
        v_d[0]  = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            r       = add_seg(k, a_q[k-1], b_q[k-1], s_q[k-1], c_q[k-1], ov_q[k-1]);
            a_d[k]  = a_q[k-1];
            b_d[k]  = b_q[k-1];
            s_d[k]  = r[WIDTH-1:0];
            c_d[k]  = r[WIDTH];
            ov_d[k] = r[WIDTH+1];
            v_d[k]  = v_q[k-1];
        end
    end

    // Data only loads with a valid slot, so outputs keep the last result across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q  <= '0;
            ov_q <= '0;
            v_q  <= '0;
        end else if (en) begin
            v_q <= v_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (v_d[k]) begin
                    a_q[k]  <= a_d[k];
                    b_q[k]  <= b_d[k];
                    s_q[k]  <= s_d[k];
                    c_q[k]  <= c_d[k];
                    ov_q[k] <= ov_d[k];
                end
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ov_q[STAGES-1];

    // Sticky overflow: a handed-off overflow beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && ovf) begin
            ovf_sticky <= 1'b1;
        end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule
